// File: rtl/lwram_ctrl.sv
// lwram_ctrl: SH2 low-work-RAM strobes to LWRAM request/ack memory port.
// One-entry posted-write buffer; WAIT_N stretches the SH2 cycle while busy.
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   A, DI, DO             SH2 word address, write data, read data
//   DCE_N, DOE_N, DWE_N   decoder chip enable, read strobe, byte write strobes
//   WAIT_N                low = stretch SH2 cycle (ANDed with decoder wait)
//   MEM_A/D/BE/WE/REQ     memory request side (REQ is a level)
//   MEM_ACK, MEM_Q        one-cycle completion pulse, read data
// Build option: define LWRAM_RDCACHE_EN for a one-entry read cache.
module lwram_ctrl #(
    parameter int AW      = 19,
    parameter int POST_WR = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW:1]   A,
    input  logic [15:0]   DI,
    output logic [15:0]   DO,
    input  logic          DCE_N,
    input  logic          DOE_N,
    input  logic [1:0]    DWE_N,
    output logic          WAIT_N,
    output logic [AW:1]   MEM_A,
    output logic [15:0]   MEM_D,
    output logic [1:0]    MEM_BE,
    output logic          MEM_WE,
    output logic          MEM_REQ,
    input  logic          MEM_ACK,
    input  logic [15:0]   MEM_Q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WREQ,
        S_RREQ,
        S_RDONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_old_rd;
    logic          r_old_wr;
    logic          r_rd_p;
    logic [AW:1]   r_rd_a;
    logic          r_wb_v;
    logic [AW:1]   r_wb_a;
    logic [15:0]   r_wb_d;
    logic [1:0]    r_wb_be;
    logic          r_pend_wr;
    logic [AW:1]   r_pd_a;
    logic [15:0]   r_pd_d;
    logic [1:0]    r_pd_be;
    logic          r_mem_req;

    logic          w_rd_start;
    logic          w_wr_start;
    logic          w_rd_go;
    logic          w_rd_req;
    logic          w_ack;
    logic          w_wr_ack;
    logic          w_rd_ack;
    logic          w_wb_free;
    logic          w_hit;
    logic [15:0]   w_c_d;
    logic [1:0]    w_be_in;

    assign w_be_in    = ~DWE_N;
    assign w_rd_start = !DOE_N & r_old_rd & !DCE_N;
    assign w_wr_start = !(&DWE_N) & r_old_wr & !DCE_N;
    // A simultaneous read edge is illegal on SH2; the write wins.
    assign w_rd_go    = w_rd_start & !w_wr_start;
    assign w_rd_req   = w_rd_go & !w_hit;
    // ACK only counts while a request is actually being presented.
    assign w_ack      = MEM_ACK & r_mem_req;
    assign w_wr_ack   = w_ack & (r_state == S_WREQ);
    assign w_rd_ack   = w_ack & (r_state == S_RREQ);
    assign w_wb_free  = !r_wb_v | w_wr_ack;

    assign MEM_REQ = r_mem_req;
    // Without posting, the buffer valid bit doubles as the write-in-flight stall.
    assign WAIT_N  = !(r_rd_p | r_pend_wr | ((POST_WR == 0) & r_wb_v));

`ifdef LWRAM_RDCACHE_EN
    logic          r_c_v;
    logic [AW:1]   r_c_a;
    logic [15:0]   r_c_d;

    // No hit while a buffered write to the same word is still outstanding.
    assign w_hit = w_rd_go & r_c_v & (r_c_a == A) &
                   !(r_wb_v & (r_wb_a == A));
    assign w_c_d = r_c_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_c_v <= 1'b0;
            r_c_a <= '0;
            r_c_d <= '0;
        end else if (w_rd_ack) begin
            r_c_v <= 1'b1;
            r_c_a <= r_rd_a;
            r_c_d <= MEM_Q;
        end else if (w_wr_start & r_c_v & (r_c_a == A)) begin
            r_c_d <= {w_be_in[1] ? DI[15:8] : r_c_d[15:8],
                      w_be_in[0] ? DI[7:0]  : r_c_d[7:0]};
        end
    end
`else
    assign w_hit = 1'b0;
    assign w_c_d = 16'h0000;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_old_rd  <= 1'b1;
            r_old_wr  <= 1'b1;
            r_rd_p    <= 1'b0;
            r_rd_a    <= '0;
            r_mem_req <= 1'b0;
            DO        <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_old_rd <= DOE_N;
            r_old_wr <= &DWE_N;
            // Second request after an ACK waits one low cycle.
            r_mem_req <= ((w_state_nxt == S_WREQ) |
                          (w_state_nxt == S_RREQ)) & !w_ack;
            if (w_rd_ack) begin
                r_rd_p <= 1'b0;
                DO     <= MEM_Q;
            end else if (w_hit) begin
                DO     <= w_c_d;
            end
            if (w_rd_req) begin
                r_rd_p <= 1'b1;
                r_rd_a <= A;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wb_v    <= 1'b0;
            r_wb_a    <= '0;
            r_wb_d    <= '0;
            r_wb_be   <= '0;
            r_pend_wr <= 1'b0;
            r_pd_a    <= '0;
            r_pd_d    <= '0;
            r_pd_be   <= '0;
        end else begin
            if (w_wr_ack) begin
                r_wb_v <= 1'b0;
            end
            if (r_pend_wr & w_wb_free) begin
                r_wb_v    <= 1'b1;
                r_wb_a    <= r_pd_a;
                r_wb_d    <= r_pd_d;
                r_wb_be   <= r_pd_be;
                r_pend_wr <= 1'b0;
            end else if (w_wr_start & w_wb_free) begin
                r_wb_v    <= 1'b1;
                r_wb_a    <= A;
                r_wb_d    <= DI;
                r_wb_be   <= w_be_in;
            end else if (w_wr_start) begin
                r_pend_wr <= 1'b1;
                r_pd_a    <= A;
                r_pd_d    <= DI;
                r_pd_be   <= w_be_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        MEM_A       = '0;
        MEM_D       = '0;
        MEM_BE      = '0;
        MEM_WE      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Buffered write first: read-after-write coherency.
                if (r_wb_v) begin
                    w_state_nxt = S_WREQ;
                end else if (r_rd_p | w_rd_req) begin
                    w_state_nxt = S_RREQ;
                end
            end
            S_WREQ: begin
                MEM_A  = r_wb_a;
                MEM_D  = r_wb_d;
                MEM_BE = r_wb_be;
                MEM_WE = 1'b1;
                if (w_ack) begin
                    w_state_nxt = (r_rd_p | w_rd_req) ? S_RREQ : S_IDLE;
                end
            end
            S_RREQ: begin
                MEM_A  = r_rd_a;
                MEM_BE = 2'b11;
                if (w_ack) begin
                    w_state_nxt = S_RDONE;
                end
            end
            S_RDONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lwram_ctrl.sv
// tb_lwram_ctrl: directed bench for lwram_ctrl.
// Cycle-vector table plus hand sequences with an auto-ACK memory model.
module tb_lwram_ctrl;

    logic          CLK;
    logic          RST_N;
    logic [19:1]   A;
    logic [15:0]   DI;
    logic [15:0]   DO;
    logic          DCE_N;
    logic          DOE_N;
    logic [1:0]    DWE_N;
    logic          WAIT_N;
    logic [19:1]   MEM_A;
    logic [15:0]   MEM_D;
    logic [1:0]    MEM_BE;
    logic          MEM_WE;
    logic          MEM_REQ;
    logic          MEM_ACK;
    logic [15:0]   MEM_Q;

    lwram_ctrl #(.AW(19), .POST_WR(1)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .A       (A),
        .DI      (DI),
        .DO      (DO),
        .DCE_N   (DCE_N),
        .DOE_N   (DOE_N),
        .DWE_N   (DWE_N),
        .WAIT_N  (WAIT_N),
        .MEM_A   (MEM_A),
        .MEM_D   (MEM_D),
        .MEM_BE  (MEM_BE),
        .MEM_WE  (MEM_WE),
        .MEM_REQ (MEM_REQ),
        .MEM_ACK (MEM_ACK),
        .MEM_Q   (MEM_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic          auto_en = 1'b0;
    logic          man_ack = 1'b0;
    logic [15:0]   man_q   = 16'h0000;
    logic          ack_auto = 1'b0;
    logic [15:0]   rd_q    = 16'h0000;
    int            dly     = 4;
    int            cnt     = 0;
    int            nreq    = 0;
    logic          prev_req = 1'b0;
    logic [37:0]   lg[$];

    assign MEM_ACK = auto_en ? ack_auto : man_ack;
    assign MEM_Q   = auto_en ? rd_q : man_q;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Memory model: ACK after dly request-high cycles, log each access.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (auto_en) begin
                if (MEM_REQ && !prev_req) nreq++;
                if (ack_auto) begin
                    ack_auto = 1'b0;
                    cnt = 0;
                end else if (MEM_REQ) begin
                    cnt++;
                    if (cnt == dly) begin
                        ack_auto = 1'b1;
                        lg.push_back({MEM_WE, MEM_BE, MEM_A, MEM_D});
                    end
                end else begin
                    cnt = 0;
                end
            end
            prev_req = MEM_REQ;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        dce_n;
        logic        doe_n;
        logic [1:0]  dwe_n;
        logic [18:0] a;
        logic [15:0] di;
        logic        ack;
        logic [15:0] q;
        logic        x_wait;
        logic        x_req;
        logic        x_we;
        logic [1:0]  x_be;
        logic [18:0] x_a;
        logic [15:0] x_d;
        logic [15:0] x_do;
    } vec_t;

    localparam logic [18:0] AR = 19'h12345;
    localparam logic [18:0] AW_ = 19'h00ABC;

    vec_t tv[19];

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic wait_hi(output int n);
        n = 0;
        while (WAIT_N == 1'b0 && n < 60) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        RST_N = 1'b0;
        A     = '0;
        DI    = '0;
        DCE_N = 1'b1;
        DOE_N = 1'b1;
        DWE_N = 2'b11;

        // Read A=0x12345, ACK in the 6th request cycle, Q=0xBEEF.
        tv[0] = '{1'b0, 1'b0, 2'b11, AR, 16'h0, 1'b0, 16'h0,
                  1'b0, 1'b1, 1'b0, 2'b11, AR, 16'h0, 16'h0};
        for (int i = 1; i < 6; i++) tv[i] = tv[0];
        tv[6] = '{1'b0, 1'b0, 2'b11, AR, 16'h0, 1'b1, 16'hBEEF,
                  1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[7] = '{1'b0, 1'b1, 2'b11, AR, 16'h0, 1'b0, 16'h0,
                  1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        // Posted low-byte write 0xA55A.
        tv[8] = '{1'b0, 1'b1, 2'b10, AW_, 16'hA55A, 1'b0, 16'h0,
                  1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[9] = '{1'b0, 1'b1, 2'b10, AW_, 16'hA55A, 1'b0, 16'h0,
                  1'b1, 1'b1, 1'b1, 2'b01, AW_, 16'hA55A, 16'hBEEF};
        tv[10] = tv[9];
        tv[11] = '{1'b0, 1'b1, 2'b10, AW_, 16'hA55A, 1'b1, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[12] = '{1'b0, 1'b1, 2'b11, AW_, 16'h0, 1'b0, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        // Stray ACK while idle.
        tv[13] = '{1'b0, 1'b1, 2'b11, AW_, 16'h0, 1'b1, 16'h1234,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        // Strobe edges with DCE_N=1 are ignored.
        tv[14] = '{1'b1, 1'b0, 2'b11, AR, 16'h0, 1'b0, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[15] = '{1'b1, 1'b1, 2'b00, AR, 16'hFFFF, 1'b0, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[16] = '{1'b1, 1'b1, 2'b11, AR, 16'h0, 1'b0, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[17] = '{1'b1, 1'b0, 2'b00, AR, 16'h0, 1'b0, 16'h0,
                   1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'hBEEF};
        tv[18] = tv[16];

        step();
        step();
        chk("rst DO", DO, 16'h0);
        chk("rst WAIT_N", WAIT_N, 1'b1);
        chk("rst REQ", MEM_REQ, 1'b0);
        chk("rst WE", MEM_WE, 1'b0);
        chk("rst MA", MEM_A, 19'h0);
        chk("rst MD", MEM_D, 16'h0);
        chk("rst BE", MEM_BE, 2'b00);
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            DCE_N   = tv[i].dce_n;
            DOE_N   = tv[i].doe_n;
            DWE_N   = tv[i].dwe_n;
            A       = tv[i].a;
            DI      = tv[i].di;
            man_ack = tv[i].ack;
            man_q   = tv[i].q;
            step();
            chk($sformatf("v%0d WAIT_N", i), WAIT_N, tv[i].x_wait);
            chk($sformatf("v%0d REQ", i), MEM_REQ, tv[i].x_req);
            chk($sformatf("v%0d WE", i), MEM_WE, tv[i].x_we);
            chk($sformatf("v%0d BE", i), MEM_BE, tv[i].x_be);
            chk($sformatf("v%0d MA", i), MEM_A, tv[i].x_a);
            chk($sformatf("v%0d MD", i), MEM_D, tv[i].x_d);
            chk($sformatf("v%0d DO", i), DO, tv[i].x_do);
        end
        man_ack = 1'b0;

        // Back-to-back writes, ACK after 8 request cycles.
        do_reset();
        auto_en = 1'b1;
        dly = 8;
        nreq = 0;
        lg.delete();
        DCE_N = 1'b0;
        DOE_N = 1'b1;
        A = 19'h00010; DI = 16'h1234; DWE_N = 2'b00;
        step();
        chk("bb wait1", WAIT_N, 1'b1);
        DWE_N = 2'b11;
        step();
        A = 19'h00020; DI = 16'h5678; DWE_N = 2'b00;
        step();
        chk("bb wait2", WAIT_N, 1'b0);
        wait_hi(n);
        chk("bb wlow", n, 7);
        chk("bb nlog1", lg.size(), 1);
        DWE_N = 2'b11;
        n = 0;
        while (lg.size() < 2 && n < 60) begin
            step();
            n++;
        end
        chk("bb nlog2", lg.size(), 2);
        chk("bb w0", lg[0], {1'b1, 2'b11, 19'h00010, 16'h1234});
        chk("bb w1", lg[1], {1'b1, 2'b11, 19'h00020, 16'h5678});
        chk("bb wait3", WAIT_N, 1'b1);
        step();
        step();

        // Write then read the same word: write reaches memory first.
        lg.delete();
        nreq = 0;
        dly = 3;
        rd_q = 16'h2222;
        A = 19'h00100; DI = 16'h1111; DWE_N = 2'b00;
        step();
        DWE_N = 2'b11; DOE_N = 1'b0;
        step();
        chk("raw wait", WAIT_N, 1'b0);
        wait_hi(n);
        chk("raw release", WAIT_N, 1'b1);
        chk("raw DO", DO, 16'h2222);
        chk("raw nreq", nreq, 2);
        chk("raw nlog", lg.size(), 2);
        chk("raw wr", lg[0], {1'b1, 2'b11, 19'h00100, 16'h1111});
        chk("raw rd", lg[1], {1'b0, 2'b11, 19'h00100, 16'h0000});
        DOE_N = 1'b1;
        step();

        // Reset while a request is outstanding.
        dly = 100;
        A = 19'h00300; DOE_N = 1'b0;
        step();
        step();
        chk("mid REQ", MEM_REQ, 1'b1);
        chk("mid WAIT_N", WAIT_N, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst REQ", MEM_REQ, 1'b0);
        chk("arst WAIT_N", WAIT_N, 1'b1);
        chk("arst DO", DO, 16'h0);
        DOE_N = 1'b1;
        step();
        RST_N = 1'b1;
        step();
        step();
        chk("arst idle", MEM_REQ, 1'b0);

`ifdef LWRAM_RDCACHE_EN
        dly = 3;
        rd_q = 16'h3C3C;
        nreq = 0;
        lg.delete();
        A = 19'h00200; DOE_N = 1'b0;
        step();
        wait_hi(n);
        chk("c fill DO", DO, 16'h3C3C);
        DOE_N = 1'b1;
        step();
        DOE_N = 1'b0;
        step();
        chk("c hit WAIT_N", WAIT_N, 1'b1);
        chk("c hit DO", DO, 16'h3C3C);
        DOE_N = 1'b1;
        step();
        chk("c nreq1", nreq, 1);
        DI = 16'h5AA5; DWE_N = 2'b01;
        step();
        DWE_N = 2'b11;
        n = 0;
        while (lg.size() < 2 && n < 60) begin
            step();
            n++;
        end
        chk("c wr done", lg.size(), 2);
        step();
        DOE_N = 1'b0;
        step();
        chk("c merge WAIT_N", WAIT_N, 1'b1);
        chk("c merge DO", DO, 16'h5A3C);
        DOE_N = 1'b1;
        step();
        chk("c nreq2", nreq, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
